// File: rtl/score_glyph_plotter.sv
// Score bitmap plotter: walks a two-digit 3x5 glyph bitmap and emits one
// scaled framebuffer pixel write per cycle, erasing clear cells as it goes.
module score_glyph_plotter #(
    parameter int         SCALE     = 2,
    parameter int         GAP       = 2,
    parameter logic [2:0] FG_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [29:0] map,
    input  logic [7:0]  x0,
    input  logic [6:0]  y0,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, DRAW, DRAIN, DONE} state_t;

    typedef struct packed {
        logic       digit;
        logic [2:0] row;
        logic [1:0] col;
        logic [1:0] sy;
        logic [1:0] sx;
    } pos_t;

    localparam logic [1:0] S_MAX       = 2'(SCALE - 1);
    localparam int         DIGIT_PITCH = 3 * SCALE + GAP;

    state_t      state_q, state_d;
    pos_t        pos_q, pos_d;
    logic [29:0] map_q, map_d;
    logic [7:0]  x0_q, x0_d;
    logic [6:0]  y0_q, y0_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        plot_q, plot_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    function automatic pos_t next_pos(input pos_t p);
        pos_t n;
        n = p;
        if (p.sx != S_MAX) begin
            n.sx = p.sx + 2'd1;
        end else begin
            n.sx = 2'd0;
            if (p.sy != S_MAX) begin
                n.sy = p.sy + 2'd1;
            end else begin
                n.sy = 2'd0;
                if (p.col != 2'd2) begin
                    n.col = p.col + 2'd1;
                end else begin
                    n.col = 2'd0;
                    if (p.row != 3'd4) begin
                        n.row = p.row + 3'd1;
                    end else begin
                        n.row   = 3'd0;
                        n.digit = ~p.digit;
                    end
                end
            end
        end
        return n;
    endfunction

    function automatic logic is_last(input pos_t p);
        return p.digit && (p.row == 3'd4) && (p.col == 2'd2) &&
               (p.sy == S_MAX) && (p.sx == S_MAX);
    endfunction

    // Sums are formed wide and truncated, so off-screen positions wrap.
    function automatic logic [7:0] pixel_x(input pos_t p, input logic [7:0] base);
        logic [15:0] sum;
        sum = 16'(base) + (p.digit ? 16'(DIGIT_PITCH) : 16'd0) +
              16'(p.col) * 16'(SCALE) + 16'(p.sx);
        return sum[7:0];
    endfunction

    function automatic logic [6:0] pixel_y(input pos_t p, input logic [6:0] base);
        logic [15:0] sum;
        sum = 16'(base) + 16'(p.row) * 16'(SCALE) + 16'(p.sy);
        return sum[6:0];
    endfunction

    function automatic logic [2:0] pixel_colour(input pos_t p, input logic [29:0] m);
        logic [14:0] glyph;
        logic [3:0]  idx;
        glyph = p.digit ? m[14:0] : m[29:15];
        idx   = {1'b0, p.row} * 4'd3 + {2'b00, p.col};
        return glyph[idx] ? FG_COLOUR : BG_COLOUR;
    endfunction

    // The start edge already emits the first pixel from the live inputs, so
    // the counters always point at the pixel to be emitted on the next edge.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        map_d    = map_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    map_d    = map;
                    x0_d     = x0;
                    y0_d     = y0;
                    x_d      = pixel_x('0, x0);
                    y_d      = pixel_y('0, y0);
                    colour_d = pixel_colour('0, map);
                    plot_d   = 1'b1;
                    busy_d   = 1'b1;
                    pos_d    = next_pos('0);
                    state_d  = DRAW;
                end
            end
            DRAW: begin
                x_d      = pixel_x(pos_q, x0_q);
                y_d      = pixel_y(pos_q, y0_q);
                colour_d = pixel_colour(pos_q, map_q);
                plot_d   = 1'b1;
                busy_d   = 1'b1;
                if (is_last(pos_q)) begin
                    pos_d   = '0;
                    state_d = DRAIN;
                end else begin
                    pos_d = next_pos(pos_q);
                end
            end
            DRAIN: begin
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                pos_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            pos_q    <= '0;
            map_q    <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            map_q    <= map_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: doc/score_glyph_plotter.md
Name: score_glyph_plotter

Overview:
- Reader side of the 30-bit two-digit score bitmap produced by the score-to-glyph decoder.
- Walks the bitmap and emits one pixel write per cycle to the VGA framebuffer write port (x, y, colour, plot), scaled and positioned on screen.
- Every glyph cell is written, set cells in foreground and clear cells in background, so the previous score is erased in the same pass.
- Started by the game controller with a one-cycle pulse; signals completion with a one-cycle done pulse.

Parameters:
SCALE, 2, screen pixels per glyph cell edge (1..4); each cell is drawn as a SCALE x SCALE square.
GAP, 2, blank columns between tens glyph and ones glyph (never written).
FG_COLOUR, 3'b111, colour for set bits.
BG_COLOUR, 3'b000, colour for clear bits.

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
start  in  1  one-cycle request to draw; sampled only in IDLE
map  in  30  glyph bitmap; [29:15] tens glyph, [14:0] ones glyph
x0  in  8  screen x of top-left corner of tens glyph
y0  in  7  screen y of top-left corner
x  out  8  pixel x
y  out  7  pixel y
colour  out  3  pixel colour
plot  out  1  pixel write strobe
busy  out  1  high while drawing
done  out  1  one-cycle completion pulse

Behaviour:
- Reset is synchronous, active-low, on clock clk; applies with resetn low at a rising edge.
- Glyph bit layout: within each 15-bit glyph, bit index = row*3 + col. Row 0 is top, row 4 bottom; col 0 is left, col 2 right.
  - Example: 15'b100100111101101 is digit 4.
- Reset values: x=0, y=0, colour=0, plot=0, busy=0, done=0, state=IDLE, all counters 0.
  - Reset mid-draw aborts immediately: next cycle plot=0, busy=0, no done pulse.
- State machine:
  - IDLE: on start=1 at an edge, latch map, x0 and y0, clear counters, go to DRAW. Otherwise stay.
  - DRAW: one pixel per cycle.
    - Loop order, outermost first: digit (0=tens, 1=ones), row (0..4), col (0..2), sy (0..SCALE-1), sx (0..SCALE-1), innermost.
    - After the last pixel (digit 1, row 4, col 2, sy=sx=SCALE-1), go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Outputs are all registered. The pixel for the current counter tuple appears with plot=1 in the cycle after the counters hold it.
  - First plot=1 is the cycle after the start edge.
  - plot stays high for exactly N = 30*SCALE*SCALE consecutive cycles.
  - done=1 in the cycle immediately after the last plot, with plot=0.
  - busy=1 from the first plot cycle through the last plot cycle.
- Pixel address:
  - x = x0 + digit*(3*SCALE + GAP) + col*SCALE + sx
  - y = y0 + row*SCALE + sy
  - Computed at full width, then truncated to 8/7 bits; off-screen coordinates wrap modulo 256/128, with no clipping.
- colour = FG_COLOUR if the latched glyph bit is 1, else BG_COLOUR. Colour and address always belong to the same pixel.
- Latched inputs: map, x0 and y0 changes during DRAW have no effect on the draw in progress.
- start while busy or in DONE is ignored and not queued. start in the same cycle as resetn=0: reset wins.
- A start in the first IDLE cycle after done begins a new draw normally, giving back-to-back draws with a 2-cycle gap between plot bursts.

Test Plan:
- Reset, then hold resetn=1 with start=0 for 10 cycles -> plot, busy and done stay 0; x=y=colour=0.
- SCALE=2, GAP=2, x0=10, y0=20, map={glyph 4, glyph 2}={15'b100100111101101,15'b111001111100111}, pulse start:
  - 120 consecutive plot cycles.
  - plot 1 = (10,20,111); plot 2 = (11,20,111); plot 3 = (10,21,111); plot 5 = (12,20,000) [tens row0 col1 clear].
  - plot 61 = (18,20,111).
  - Last plot = (23,29,111).
  - done one cycle later.
- Full-bitmap check, same draw: every set cell yields SCALE*SCALE FG pixels and every clear cell BG pixels. Per glyph: 4 -> 9 set cells (36 FG pixels), 2 -> 11 set cells (44 FG pixels). Columns x=16,17 (GAP) never written.
- Pulse start again at plot 50, and change map to all ones at plot 50 -> burst length still 120; pixel colours match the original latched map.
- Assert resetn=0 at plot 30 -> next cycle plot=0, busy=0, no done. A subsequent start yields a full 120-pixel draw from (x0,y0).
- x0=250, y0=125, SCALE=1, map=all ones -> 30 plots with wrapped coordinates, e.g. ones glyph col0 at x=(250+5)%256=255 and col1 at x=0; row 3 at y=0.
